icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameters: ADDR_W, default 64, address width; DATA_W, default 64, beat width; INDEX_W, default 6, set-index width; LINE_BEATS, default 4, beats per line (power of two, at least 2).
REQ-002 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  miss  in  1  miss from tag stage.
  miss_addr  in  ADDR_W  missing fetch address.
  victim_way  in  1  LRU way from tag stage.
  flush  in  1  cancel pending refill.
  refresh  out  1  one-cycle tag-update pulse.
  busy  out  1  refill in progress.
  mem_req  out  1  burst read request valid.
  mem_gnt  in  1  request accepted.
  mem_addr  out  ADDR_W  line-aligned burst address.
  mem_len  out  8  LINE_BEATS-1.
  mem_rvalid  in  1  read beat valid.
  mem_rdata  in  DATA_W  read beat data.
  mem_rlast  in  1  final beat.
  mem_rerr  in  1  beat error.
  mem_rready  out  1  beat accept.
  data_we  out  1  data-array write enable.
  data_way  out  1  target way.
  data_index  out  INDEX_W  target set.
  data_beat  out  log2(LINE_BEATS)  word in line.
  data_wdata  out  DATA_W  write data.
  fwd_valid  out  1  critical word ready.
  fwd_data  out  DATA_W  critical word.
  err  out  1  one-cycle bus-error pulse.

Function
REQ-003 SHALL implement FSM IDLE, REQ, RECV, REFRESH, DONE.
REQ-004 IDLE: on miss=1, SHALL latch miss_addr and victim_way and enter REQ next cycle; busy=1 in all states except IDLE.
REQ-005 REQ: mem_req=1, mem_addr = latched address with the low log2(LINE_BEATS*DATA_W/8) bits cleared; on mem_req&mem_gnt, enter RECV.
REQ-006 RECV: mem_rready=1; each mem_rvalid beat SHALL drive data_we=1 in the same cycle, with data_wdata=mem_rdata, data_beat equal to the beat counter, and data_way/data_index from the latched values.
REQ-007 The beat counter SHALL start at 0 and increment per accepted beat, wrapping modulo LINE_BEATS.
REQ-008 The beat with mem_rlast=1 or counter=LINE_BEATS-1, whichever comes first, SHALL end RECV and enter REFRESH.
REQ-009 REFRESH SHALL assert refresh=1 for exactly one cycle, then enter DONE.
REQ-010 DONE SHALL last one cycle so the tag stage can re-look-up as a hit, then enter IDLE.
REQ-011 miss while busy=1 SHALL be ignored.
REQ-012 flush in REQ before the grant SHALL return the FSM to IDLE next cycle with no memory request.
REQ-013 flush after the grant SHALL drain all remaining beats with data_we=0 for those beats, then go to IDLE without refresh.
REQ-014 Any beat with mem_rerr=1 SHALL suppress data_we for that beat and suppress refresh for the line; err SHALL pulse one cycle when RECV ends.
REQ-015 Simultaneous flush and error SHALL give no refresh and one err pulse.
REQ-016 Worst-case miss-to-refresh latency, with single-cycle grant and back-to-back beats, SHALL be LINE_BEATS+2 cycles.

Reset
REQ-017 rst=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0, including while mid-burst.
REQ-018 After rst deasserts, a refill SHALL start only on a new miss.

Configuration
REQ-019 Macro ICACHE_CRITICAL_WORD_FIRST_EN, when defined:
  - SHALL set fwd_valid=1 for one cycle, with fwd_data=mem_rdata, on the beat whose index equals the miss word offset.
  - SHALL not assert fwd_valid when that beat is flushed or in error.
REQ-020 Without the macro, fwd_valid SHALL be tied to 0 and fwd_data to 0.

Structure
REQ-021 The shared package/defines SHALL hold the FSM state encoding, LINE_BEATS, INDEX_W, and the offset-width constants used by both icache_tag and icache_refill.
REQ-022 The beat counter and last-beat detection SHALL be a sub-module icache_beat_cnt; everything else stays inline.

Verification
REQ-023 Single refill: miss, miss_addr=0x8000_0048, victim_way=1, gnt at cycle 2, 4 beats A0..A3 -> data_we on 4 cycles with data_beat 0..3, data_index=0x02, data_way=1; refresh pulses once on the cycle after the last beat.
REQ-024 Stalled memory: mem_rvalid gaps of 3 cycles between beats -> no extra data_we pulses; counter holds during gaps; refresh still pulses exactly once.
REQ-025 Flush: flush in REQ -> mem_req drops the next cycle with no burst; flush after beat 1 -> beats 2-3 accepted with data_we=0 and no refresh.
REQ-026 Error: mem_rerr on beat 2 -> data_we=0 for beat 2, no refresh, err=1 for one cycle.
REQ-027 Reset mid-burst: rst=0 after beat 1 -> all outputs 0 immediately; after release, the FSM stays IDLE until a new miss.
REQ-028 With the macro: miss_addr offset word 2 -> fwd_valid=1 on beat 2 with fwd_data=A2; without the macro -> fwd_valid stays 0.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill path.
// Holds the refill FSM state encoding, the default line geometry
// (LINE_BEATS, INDEX_W, address/data widths) and the helpers that derive
// the byte-offset and line-offset widths. The tag stage and the refill
// engine both take their offset arithmetic from here, so they always agree
// on which address bits select the set and the word.
package icache_refill_pkg;

  localparam int unsigned ADDR_W_DEF     = 32'd64;
  localparam int unsigned DATA_W_DEF     = 32'd64;
  localparam int unsigned INDEX_W_DEF    = 32'd6;
  localparam int unsigned LINE_BEATS_DEF = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RECV    = 3'd2,
    ST_REFRESH = 3'd3,
    ST_DONE    = 3'd4
  } refill_state_e;

  // Address bits that select a byte inside one beat.
  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 32'd8);
  endfunction

  // Address bits that select a byte inside one line.
  function automatic int unsigned line_off_w(input int unsigned beats,
                                             input int unsigned data_w);
    return $clog2(beats * (data_w / 32'd8));
  endfunction

endpackage

// File: rtl/icache_beat_cnt.sv
// Beat counter for one refill burst.
// Counts accepted read beats from 0, wraps modulo LINE_BEATS and flags the
// beat that ends the burst (early mem_rlast or the final beat of the line).
// Ports:
//   clk, rst  - clock and asynchronous active-low reset
//   clear     - hold the counter at zero (refill engine idle)
//   adv       - a beat is accepted this cycle
//   rlast     - memory marks this beat as the last one
//   cnt       - index of the beat currently on the bus
//   last      - this accepted beat ends the burst
module icache_beat_cnt
  import icache_refill_pkg::*;
#(
  parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          adv,
  input  logic                          rlast,
  output logic [$clog2(LINE_BEATS)-1:0] cnt,
  output logic                          last
);

  localparam int unsigned CNT_W = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LINE_BEATS - 32'd1);

  logic [CNT_W-1:0] cnt_r;

  assign last = adv && (rlast || (cnt_r == MAX_CNT));
  assign cnt  = cnt_r;

  // Beat index: restarts after the burst-ending beat so the next line starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (adv) begin
      if (last) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine.
// On a tag-stage miss it captures the address and victim way, issues one
// line-aligned burst read, writes each returned beat into the data array,
// then pulses refresh so the tag stage installs the line, and holds one
// DONE cycle so the re-look-up hits. Flush cancels the refill (draining any
// beats already granted); a bus error drops the line and pulses err.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   miss/miss_addr/victim_way- miss request from the tag stage
//   flush                    - cancel the pending refill
//   refresh, busy            - tag-update pulse, refill in progress
//   mem_req/gnt/addr/len     - burst read request channel
//   mem_rvalid/rdata/rlast/rerr/rready - read beat channel
//   data_we/way/index/beat/wdata       - data-array write port
//   fwd_valid/fwd_data       - critical word forward to the fetch stage
//   err                      - one-cycle bus-error pulse at end of burst
// Build option: define ICACHE_CRITICAL_WORD_FIRST_EN to forward the missing
// word as it arrives; otherwise fwd_valid/fwd_data are tied low.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned INDEX_W    = INDEX_W_DEF,
  parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss,
  input  logic [ADDR_W-1:0]             miss_addr,
  input  logic                          victim_way,
  input  logic                          flush,
  output logic                          refresh,
  output logic                          busy,
  output logic                          mem_req,
  input  logic                          mem_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_len,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rlast,
  input  logic                          mem_rerr,
  output logic                          mem_rready,
  output logic                          data_we,
  output logic                          data_way,
  output logic [INDEX_W-1:0]            data_index,
  output logic [$clog2(LINE_BEATS)-1:0] data_beat,
  output logic [DATA_W-1:0]             data_wdata,
  output logic                          fwd_valid,
  output logic [DATA_W-1:0]             fwd_data,
  output logic                          err
);

  localparam int unsigned BEAT_W    = $clog2(LINE_BEATS);
  localparam int unsigned BYTE_W    = byte_off_w(DATA_W);
  localparam int unsigned OFF_W     = line_off_w(LINE_BEATS, DATA_W);
  localparam logic [7:0]  BURST_LEN = 8'(LINE_BEATS - 32'd1);

  refill_state_e      state_r;
  logic               way_r;
  logic [INDEX_W-1:0] index_r;
  logic               flushed_r;
  logic               bad_r;
  logic               busy_r;
  logic               mem_req_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [7:0]         mem_len_r;
  logic               mem_rready_r;
  logic               refresh_r;
  logic               err_r;

  logic               beat_acc_s;
  logic               kill_s;
  logic               beat_ok_s;
  logic               cnt_clear_s;
  logic [BEAT_W-1:0]  cnt_s;
  logic               last_s;
  logic               unused_s;

  // Line-offset bits only matter for word forwarding; keep them visibly consumed.
  assign unused_s = ^miss_addr[OFF_W-1:0];

  assign beat_acc_s  = (state_r == ST_RECV) && mem_rvalid;
  // A flush on the beat's own cycle already cancels that beat.
  assign kill_s      = flush || flushed_r;
  assign beat_ok_s   = beat_acc_s && !kill_s && !mem_rerr;
  assign cnt_clear_s = (state_r == ST_IDLE);

  icache_beat_cnt #(
    .LINE_BEATS (LINE_BEATS)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear_s),
    .adv   (beat_acc_s),
    .rlast (mem_rlast),
    .cnt   (cnt_s),
    .last  (last_s)
  );

  // Data-array writes follow the beat in the same cycle.
  assign data_we    = beat_ok_s;
  assign data_wdata = beat_ok_s ? mem_rdata : {DATA_W{1'b0}};
  assign data_beat  = cnt_s;
  assign data_way   = way_r;
  assign data_index = index_r;

  assign refresh    = refresh_r;
  assign busy       = busy_r;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_len    = mem_len_r;
  assign mem_rready = mem_rready_r;
  assign err        = err_r;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [BEAT_W-1:0] crit_r;

  assign fwd_valid = beat_ok_s && (cnt_s == crit_r);
  assign fwd_data  = fwd_valid ? mem_rdata : {DATA_W{1'b0}};
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = {DATA_W{1'b0}};
`endif

  // Refill sequencing: capture miss, request burst, receive beats, refresh tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      way_r        <= 1'b0;
      index_r      <= {INDEX_W{1'b0}};
      flushed_r    <= 1'b0;
      bad_r        <= 1'b0;
      busy_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_len_r    <= 8'd0;
      mem_rready_r <= 1'b0;
      refresh_r    <= 1'b0;
      err_r        <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      crit_r       <= {BEAT_W{1'b0}};
`endif
    end else begin
      refresh_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (miss) begin
            state_r    <= ST_REQ;
            way_r      <= victim_way;
            index_r    <= miss_addr[OFF_W +: INDEX_W];
            mem_addr_r <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_len_r  <= BURST_LEN;
            mem_req_r  <= 1'b1;
            busy_r     <= 1'b1;
            flushed_r  <= 1'b0;
            bad_r      <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            crit_r     <= miss_addr[BYTE_W +: BEAT_W];
`endif
          end
        end
        ST_REQ: begin
          // Once granted the burst must be drained, so a simultaneous flush
          // only marks the line as cancelled.
          if (mem_gnt) begin
            state_r      <= ST_RECV;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_len_r    <= 8'd0;
            mem_rready_r <= 1'b1;
            flushed_r    <= flush;
          end else if (flush) begin
            state_r    <= ST_IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_len_r  <= 8'd0;
            busy_r     <= 1'b0;
          end
        end
        ST_RECV: begin
          if (flush) begin
            flushed_r <= 1'b1;
          end
          if (beat_acc_s && mem_rerr) begin
            bad_r <= 1'b1;
          end
          if (last_s) begin
            mem_rready_r <= 1'b0;
            err_r        <= bad_r || mem_rerr;
            if (kill_s || bad_r || mem_rerr) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= ST_REFRESH;
              refresh_r <= 1'b1;
            end
          end
        end
        ST_REFRESH: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          mem_req_r    <= 1'b0;
          mem_addr_r   <= {ADDR_W{1'b0}};
          mem_len_r    <= 8'd0;
          mem_rready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a transaction-level reference model.
// Line geometry: 4 beats of 8 bytes = 32-byte lines, 6 index bits.
module tb_icache_refill;

  localparam int LB = 4;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss = 1'b0;
  logic [63:0] miss_addr = 64'd0;
  logic        victim_way = 1'b0;
  logic        flush = 1'b0;
  logic        refresh, busy, mem_req;
  logic        mem_gnt = 1'b0;
  logic [63:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_rlast = 1'b0;
  logic        mem_rerr = 1'b0;
  logic        mem_rready, data_we, data_way;
  logic [5:0]  data_index;
  logic [1:0]  data_beat;
  logic [63:0] data_wdata;
  logic        fwd_valid;
  logic [63:0] fwd_data;
  logic        err;

  icache_refill dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr),
    .victim_way(victim_way), .flush(flush), .refresh(refresh), .busy(busy),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .mem_rerr(mem_rerr), .mem_rready(mem_rready), .data_we(data_we),
    .data_way(data_way), .data_index(data_index), .data_beat(data_beat),
    .data_wdata(data_wdata), .fwd_valid(fwd_valid), .fwd_data(fwd_data), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int miss_cyc = 0;
  int refresh_cyc = 0;
  int ev_we = 0, ev_refresh = 0, ev_err = 0, ev_fwd = 0;
  logic [63:0] last_fwd = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 requesting, 2 receiving, 3 tag refresh, 4 re-look-up
  int          m_phase = 0;
  logic [63:0] m_line = 64'd0;
  logic [5:0]  m_index = 6'd0;
  logic        m_way = 1'b0;
  int          m_word = 0;
  int          m_nbeat = 0;
  bit          m_cancel = 1'b0;
  bit          m_bad = 1'b0;
  bit          m_errp = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = 0; m_line = 64'd0; m_index = 6'd0; m_way = 1'b0;
        m_word = 0; m_nbeat = 0; m_cancel = 1'b0; m_bad = 1'b0; m_errp = 1'b0;
      end else begin
        m_errp = 1'b0;
        if (m_phase == 0) begin
          if (miss) begin
            m_phase  = 1;
            m_line   = miss_addr & ~64'h1F;
            m_index  = 6'((miss_addr >> 5) & 64'h3F);
            m_word   = int'((miss_addr >> 3) & 64'h3);
            m_way    = victim_way;
            m_cancel = 1'b0;
            m_bad    = 1'b0;
            m_nbeat  = 0;
          end
        end else if (m_phase == 1) begin
          if (mem_gnt) begin
            m_phase  = 2;
            m_cancel = flush;
          end else if (flush) begin
            m_phase = 0;
          end
        end else if (m_phase == 2) begin
          if (flush) m_cancel = 1'b1;
          if (mem_rvalid) begin
            if (mem_rerr) m_bad = 1'b1;
            if (mem_rlast || m_nbeat == LB - 1) begin
              m_nbeat = 0;
              m_errp  = m_bad;
              m_phase = (m_cancel || m_bad) ? 0 : 3;
            end else begin
              m_nbeat = m_nbeat + 1;
            end
          end
        end else if (m_phase == 3) begin
          m_phase = 4;
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_we, e_fwd;
  always @(negedge clk) begin
    e_we  = (m_phase == 2) && mem_rvalid && !(m_cancel || flush) && !mem_rerr;
    e_fwd = CWF && e_we && (m_nbeat == m_word);
    chk("busy", busy, m_phase != 0);
    chk("mem_req", mem_req, m_phase == 1);
    chk("mem_addr", mem_addr, (m_phase == 1) ? m_line : 64'd0);
    chk("mem_len", mem_len, (m_phase == 1) ? 64'(LB - 1) : 64'd0);
    chk("mem_rready", mem_rready, m_phase == 2);
    chk("refresh", refresh, m_phase == 3);
    chk("err", err, m_errp);
    chk("data_we", data_we, e_we);
    chk("data_wdata", data_wdata, e_we ? mem_rdata : 64'd0);
    chk("data_beat", data_beat, 64'(m_nbeat));
    chk("data_index", data_index, m_index);
    chk("data_way", data_way, m_way);
    chk("fwd_valid", fwd_valid, e_fwd);
    chk("fwd_data", fwd_data, e_fwd ? mem_rdata : 64'd0);
    if (data_we) ev_we++;
    if (refresh) begin ev_refresh++; refresh_cyc = cyc; end
    if (err) ev_err++;
    if (fwd_valid) begin ev_fwd++; last_fwd = fwd_data; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    ev_we = 0; ev_refresh = 0; ev_err = 0; ev_fwd = 0; last_fwd = 64'd0;
  endtask

  task automatic miss_req(input logic [63:0] a, input logic w);
    miss = 1'b1; miss_addr = a; victim_way = w; miss_cyc = cyc;
    step();
    miss = 1'b0; miss_addr = 64'hFFFF_FFFF_FFFF_FFFF; victim_way = ~w;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
  endtask

  // n beats, `gap` idle cycles between beats; err_at/flush_at pick a beat (-1 none)
  task automatic burst(input logic [63:0] base, input int n, input int gap,
                       input int err_at, input int flush_at, input bit pin);
    for (int i = 0; i < n; i++) begin
      if (i > 0) for (int g = 0; g < gap; g++) step();
      mem_rvalid = 1'b1; mem_rdata = base + 64'(i); mem_rlast = (i == n - 1);
      mem_rerr = (i == err_at); flush = (i == flush_at);
      #1;
      if (pin) begin
        chk("t1_we", data_we, 64'd1);
        chk("t1_beat", data_beat, 64'(i));
        chk("t1_wdata", data_wdata, base + 64'(i));
      end
      step();
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rerr = 1'b0; flush = 1'b0; mem_rdata = 64'd0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 64'd0);
    chk("rst_mem_req", mem_req, 64'd0);
    chk("rst_refresh", refresh, 64'd0);
    rst = 1'b1;
    repeat (2) step();

    // T1: single refill
    clr_ev();
    miss_req(64'h8000_0048, 1'b1);
    chk("t1_mem_req", mem_req, 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h8000_0040);
    chk("t1_mem_len", mem_len, 64'd3);
    grant();
    chk("t1_index", data_index, 64'h02);
    chk("t1_way", data_way, 64'd1);
    burst(64'hA000_0000_0000_0000, 4, 0, -1, -1, 1'b1);
    repeat (3) step();
    chk("t1_we_count", ev_we, 64'd4);
    chk("t1_refresh_count", ev_refresh, 64'd1);
    chk("t1_latency", 64'(refresh_cyc - miss_cyc), 64'd6);
    chk("t1_fwd_count", ev_fwd, CWF ? 64'd1 : 64'd0);
    chk("t1_busy_end", busy, 64'd0);

    // T2: stalled memory, 3-cycle gaps
    clr_ev();
    miss_req(64'h0000_1F60, 1'b0);
    grant();
    chk("t2_index", data_index, 64'h3B);
    burst(64'hB000_0000_0000_0000, 4, 3, -1, -1, 1'b0);
    repeat (3) step();
    chk("t2_we_count", ev_we, 64'd4);
    chk("t2_refresh_count", ev_refresh, 64'd1);

    // T3: flush while requesting
    clr_ev();
    miss_req(64'h0000_2000, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_mem_req", mem_req, 64'd0);
    chk("t3_busy", busy, 64'd0);
    repeat (4) step();
    chk("t3_refresh_count", ev_refresh, 64'd0);
    chk("t3_mem_req_later", mem_req, 64'd0);

    // T4: flush with beat 2
    clr_ev();
    miss_req(64'h4000_0000, 1'b0);
    grant();
    burst(64'hC000_0000_0000_0000, 4, 0, -1, 2, 1'b0);
    repeat (3) step();
    chk("t4_we_count", ev_we, 64'd2);
    chk("t4_refresh_count", ev_refresh, 64'd0);
    chk("t4_err_count", ev_err, 64'd0);
    chk("t4_busy", busy, 64'd0);

    // T5: error on beat 2
    clr_ev();
    miss_req(64'h4000_0100, 1'b1);
    grant();
    burst(64'hD000_0000_0000_0000, 4, 0, 2, -1, 1'b0);
    repeat (3) step();
    chk("t5_we_count", ev_we, 64'd3);
    chk("t5_refresh_count", ev_refresh, 64'd0);
    chk("t5_err_count", ev_err, 64'd1);

    // T6: flush and error together on beat 1
    clr_ev();
    miss_req(64'h4000_0200, 1'b0);
    grant();
    burst(64'hD100_0000_0000_0000, 4, 0, 1, 1, 1'b0);
    repeat (3) step();
    chk("t6_we_count", ev_we, 64'd1);
    chk("t6_refresh_count", ev_refresh, 64'd0);
    chk("t6_err_count", ev_err, 64'd1);

    // T7: reset in the middle of a burst
    clr_ev();
    miss_req(64'h8000_0048, 1'b1);
    grant();
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'h77 + 64'(i);
      step();
    end
    mem_rdata = 64'h79;
    #2;
    rst = 1'b0;
    #1;
    chk("t7_busy", busy, 64'd0);
    chk("t7_rready", mem_rready, 64'd0);
    chk("t7_we", data_we, 64'd0);
    chk("t7_wdata", data_wdata, 64'd0);
    chk("t7_beat", data_beat, 64'd0);
    chk("t7_index", data_index, 64'd0);
    chk("t7_way", data_way, 64'd0);
    mem_rvalid = 1'b0; mem_rdata = 64'd0;
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    chk("t7_idle_busy", busy, 64'd0);
    chk("t7_idle_req", mem_req, 64'd0);
    chk("t7_refresh_count", ev_refresh, 64'd0);

    // T8: critical word at offset 2
    clr_ev();
    miss_req(64'h0000_0090, 1'b0);
    grant();
    chk("t8_index", data_index, 64'h04);
    burst(64'hE000_0000_0000_0000, 4, 0, -1, -1, 1'b0);
    repeat (3) step();
    chk("t8_fwd_count", ev_fwd, CWF ? 64'd1 : 64'd0);
    chk("t8_fwd_data", last_fwd, CWF ? 64'hE000_0000_0000_0002 : 64'd0);
    chk("t8_refresh_count", ev_refresh, 64'd1);

    // T9: early rlast after 2 beats, with a miss held during the burst
    clr_ev();
    miss_req(64'h0000_0120, 1'b1);
    grant();
    miss = 1'b1; miss_addr = 64'h5555_0000; victim_way = 1'b0;
    burst(64'hF000_0000_0000_0000, 2, 0, -1, -1, 1'b0);
    miss = 1'b0;
    repeat (3) step();
    chk("t9_we_count", ev_we, 64'd2);
    chk("t9_refresh_count", ev_refresh, 64'd1);
    chk("t9_index", data_index, 64'h09);
    chk("t9_way", data_way, 64'd1);
    chk("t9_busy", busy, 64'd0);
    chk("t9_beat", data_beat, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
